// File: rtl/upe_led_serializer.sv
// upe_led_serializer
//
// Shows one adder result on a single board LED as a slow serial frame. The
// frame opens with a dark gap, followed by the data bits LSB first. When
// CARRY_EN is 1, the carry-out is sent as one extra bit after the data MSB.
// The design runs from the 10 kHz low-frequency oscillator. Each bit, and
// each gap slot, stays on the LED for BIT_CYCLES clocks.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : in_data/in_carry hold a word
//   in_ready   : block can take a word this cycle (registered)
//   in_data    : WIDTH-bit adder sum
//   in_carry   : adder carry-out
//   led        : serial bit to the LED (registered, no input-to-led path)
//   busy       : high while a frame is in progress
//   bit_idx    : index of the data bit currently on led (0 outside SHIFT)
//   frame_done : one-cycle pulse in the cycle after the last bit
//   dbg_state  : current FSM state (IDLE=0, GAP=1, SHIFT=2, DONE=3)
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE and DONE. A word offered
// while busy is ignored and does not stall the frame. After a word is
// captured, later changes on in_data/in_carry have no effect.
module upe_led_serializer #(
  parameter int WIDTH      = 64,
  parameter int CARRY_EN   = 1,
  parameter int BIT_CYCLES = 1250,
  parameter int GAP_BITS   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  output logic             led,
  output logic             busy,
  output logic [6:0]       bit_idx,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  localparam int NBITS = WIDTH + CARRY_EN;
  localparam int PW    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_BITS - 1);
  localparam logic [6:0]    IDX_LAST   = 7'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [GW-1:0]    gap_cnt;
  logic [NBITS-1:0] shift_reg;

  logic [NBITS-1:0] capture_word;
  logic [NBITS-1:0] shifted;
  logic             presc_tc;
  logic             accept;

  // When CARRY_EN is 0, NBITS equals WIDTH and the cast drops the carry bit.
  assign capture_word = NBITS'({in_carry, in_data});
  assign shifted      = shift_reg >> 1;
  assign presc_tc     = (presc == PRESC_LAST);
  assign accept       = in_valid && in_ready;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      led        <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= 7'd0;
      presc      <= '0;
      gap_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for intake, so back-to-back words lose
        // only the single DONE cycle between frames.
        IDLE, DONE: begin
          led     <= 1'b0;
          bit_idx <= 7'd0;
          if (accept) begin
            shift_reg <= capture_word;
            state     <= GAP;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            presc     <= '0;
            gap_cnt   <= '0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        GAP: begin
          led <= 1'b0;
          if (presc_tc) begin
            presc <= '0;
            if (gap_cnt == GAP_LAST) begin
              // Load bit 0 now so it is already on led in the first SHIFT cycle.
              state   <= SHIFT;
              led     <= shift_reg[0];
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        SHIFT: begin
          if (presc_tc) begin
            presc <= '0;
            if (bit_idx == IDX_LAST) begin
              state      <= DONE;
              led        <= 1'b0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              bit_idx    <= 7'd0;
            end else begin
              shift_reg <= shifted;
              led       <= shifted[0];
              bit_idx   <= bit_idx + 7'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upe_led_serializer.sv
// Bench for upe_led_serializer. It drives two instances:
//   s_* : small configuration (8 data bits + carry, 4 cycles/bit, 2 gap slots)
//   b_* : 64-bit word + carry, 4 gap slots, 50 cycles/bit
// Inputs change 2 time units after a rising edge. Outputs are sampled on the
// falling edge. The per-instance model tracks k, the number of edges since
// the accepting edge, and derives the full expected status from it.
module tb_upe_led_serializer;

  localparam int S_W   = 8;
  localparam int S_BC  = 4;
  localparam int S_GB  = 2;
  localparam int S_NB  = S_W + 1;
  localparam int S_GAP = S_GB * S_BC;
  localparam int S_END = (S_GB + S_NB) * S_BC;

  localparam int B_W   = 64;
  localparam int B_BC  = 50;
  localparam int B_GB  = 4;
  localparam int B_NB  = B_W + 1;
  localparam int B_GAP = B_GB * B_BC;
  localparam int B_END = (B_GB + B_NB) * B_BC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           s_reset, s_valid, s_ready, s_carry, s_led, s_busy, s_fd;
  logic [S_W-1:0] s_data;
  logic [6:0]     s_idx;
  logic [1:0]     s_state;

  logic           b_reset, b_valid, b_ready, b_carry, b_led, b_busy, b_fd;
  logic [B_W-1:0] b_data;
  logic [6:0]     b_idx;
  logic [1:0]     b_state;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;
  bit b_done = 1'b0;

  upe_led_serializer #(.WIDTH(S_W), .CARRY_EN(1), .BIT_CYCLES(S_BC), .GAP_BITS(S_GB)) u_small (
    .clk(clk), .reset(s_reset), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .in_carry(s_carry), .led(s_led), .busy(s_busy),
    .bit_idx(s_idx), .frame_done(s_fd), .dbg_state(s_state)
  );

  upe_led_serializer #(.WIDTH(B_W), .CARRY_EN(1), .BIT_CYCLES(B_BC), .GAP_BITS(B_GB)) u_big (
    .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_carry(b_carry), .led(b_led), .busy(b_busy),
    .bit_idx(b_idx), .frame_done(b_fd), .dbg_state(b_state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  // status vector = {led, frame_done, busy, in_ready, bit_idx[6:0], state[1:0]}
  logic [S_NB-1:0] s_exp_q[$];
  logic [S_NB-1:0] s_cur = '0;
  bit              s_act = 1'b0;
  int              s_k   = 0;
  logic [12:0]     s_e;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!s_act)             s_e = {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 2'd0};
      else if (s_k < S_GAP)   s_e = {1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 2'd1};
      else if (s_k < S_END)   s_e = {s_cur[(s_k - S_GAP) / S_BC], 1'b0, 1'b1, 1'b0,
                                     7'((s_k - S_GAP) / S_BC), 2'd2};
      else                    s_e = {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 2'd3};
      chk("s_status", {s_led, s_fd, s_busy, s_ready, s_idx, s_state}, s_e);
      // Advance the model to match the upcoming edge.
      if (s_reset) begin
        s_act <= 1'b0;
      end else if (s_valid && s_ready) begin
        chk("s_accept_queued", 128'(s_exp_q.size() != 0), 128'(1));
        if (s_exp_q.size() != 0) s_cur <= s_exp_q.pop_front();
        s_act <= 1'b1;
        s_k   <= 0;
      end else if (s_act) begin
        if (s_k == S_END) s_act <= 1'b0;
        else              s_k   <= s_k + 1;
      end
    end
  end

  logic [B_NB-1:0] b_exp_q[$];
  logic [B_NB-1:0] b_cur = '0;
  bit              b_act = 1'b0;
  int              b_k   = 0;
  logic [12:0]     b_e;

  always @(negedge clk) begin
    if (mon_on) begin
      if (!b_act)             b_e = {1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 2'd0};
      else if (b_k < B_GAP)   b_e = {1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 2'd1};
      else if (b_k < B_END)   b_e = {b_cur[(b_k - B_GAP) / B_BC], 1'b0, 1'b1, 1'b0,
                                     7'((b_k - B_GAP) / B_BC), 2'd2};
      else                    b_e = {1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 2'd3};
      chk("b_status", {b_led, b_fd, b_busy, b_ready, b_idx, b_state}, b_e);
      if (b_reset) begin
        b_act <= 1'b0;
      end else if (b_valid && b_ready) begin
        chk("b_accept_queued", 128'(b_exp_q.size() != 0), 128'(1));
        if (b_exp_q.size() != 0) b_cur <= b_exp_q.pop_front();
        b_act <= 1'b1;
        b_k   <= 0;
      end else if (b_act) begin
        if (b_k == B_END) b_act <= 1'b0;
        else              b_k   <= b_k + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called 2 time units after a rising edge. Returns the same distance after
  // the accepting edge. With keep=1, in_valid stays high.
  task automatic s_send(input logic [S_W-1:0] d, input logic c, input bit keep);
    int t;
    s_exp_q.push_back({c, d});
    s_valid = 1'b1;
    s_data  = d;
    s_carry = c;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("s_send_ready", 128'(s_ready), 128'(1));
    @(posedge clk);
    #2;
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic s_poke_busy(input logic [S_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    s_carry = 1'b1;
    @(negedge clk);
    chk("s_busy_ready", 128'(s_ready), 128'(0));
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic s_wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!s_fd && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("s_frame_done_seen", 128'(s_fd), 128'(1));
    @(posedge clk);
    #2;
  endtask

  task automatic b_send(input logic [B_W-1:0] d, input logic c);
    int t;
    b_exp_q.push_back({c, d});
    b_valid = 1'b1;
    b_data  = d;
    b_carry = c;
    t = 0;
    @(negedge clk);
    while (!b_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("b_send_ready", 128'(b_ready), 128'(1));
    @(posedge clk);
    #2;
    b_valid = 1'b0;
  endtask

  // ---------------- 64-bit stimulus ----------------
  initial begin : big_flow
    logic [B_W-1:0] x1, x2;
    logic [B_W:0]   sum;
    int t;
    b_reset = 1'b1;
    b_valid = 1'b0;
    b_data  = '0;
    b_carry = 1'b0;
    repeat (3) @(posedge clk);
    #2 b_reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    x1  = 64'h5CD5153134D51531;
    x2  = 64'hFFFFFFFFFFFFFFFF;
    sum = {1'b0, x1} + {1'b0, x2} + 65'd1;
    b_send(sum[B_W-1:0], sum[B_W]);
    t = 0;
    @(negedge clk);
    while (!b_fd && t < B_END + 100) begin
      @(negedge clk);
      t++;
    end
    chk("b_frame_done_seen", 128'(b_fd), 128'(1));
    repeat (3) @(posedge clk);
    b_done = 1'b1;
  end

  // ---------------- small-config stimulus + report ----------------
  initial begin : main_flow
    int t;
    s_reset = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_carry = 1'b0;
    @(posedge clk);
    #2 mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 s_reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    // Basic frame 0xA5 + carry 1.
    s_send(8'hA5, 1'b1, 1'b0);
    s_wait_done();
    repeat (3) @(posedge clk);
    #2;

    // Word offered mid-SHIFT is ignored.
    s_send(8'hA5, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    s_poke_busy(8'hFF);
    s_wait_done();
    repeat (2) @(posedge clk);
    #2;

    // Reset during bit 3 aborts the frame; the next word gets a full gap.
    s_send(8'h3C, 1'b0, 1'b0);
    repeat (21) @(posedge clk);
    #2 s_reset = 1'b1;
    @(posedge clk);
    #2 s_reset = 1'b0;
    @(negedge clk);
    chk("s_led_after_reset", 128'(s_led), 128'(0));
    repeat (4) @(posedge clk);
    #2;
    s_send(8'h5A, 1'b0, 1'b0);
    s_wait_done();
    repeat (2) @(posedge clk);
    #2;

    // Back-to-back frames with in_valid held high.
    s_send(8'h01, 1'b0, 1'b1);
    s_send(8'h80, 1'b1, 1'b0);
    s_wait_done();
    repeat (3) @(posedge clk);
    #2;
    s_send(8'h6E, 1'b0, 1'b0);
    s_wait_done();

    t = 0;
    while (!b_done && t < 10000) begin
      @(posedge clk);
      t++;
    end
    chk("b_flow_finished", 128'(b_done), 128'(1));
    chk("s_queue_empty", 128'(s_exp_q.size()), 128'(0));
    chk("b_queue_empty", 128'(b_exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/upe_led_serializer.md
Name: upe_led_serializer

Overview:
- Downstream consumer of the upe adder result.
- Accepts one WIDTH-bit sum plus its carry-out through a valid/ready handshake.
- Shows the captured word on a single LED as a slow, LSB-first bit stream, preceded by a dark gap that marks the frame start.
- Sits between the upe adder core and the iCE40 board LED, clocked from the 10 kHz SB_LFOSC clock.

Parameters:
- WIDTH, 64: data bits per word.
- CARRY_EN, 1: when 1, in_carry is sent as an extra bit after the data MSB. NBITS = WIDTH + CARRY_EN.
- BIT_CYCLES, 1250: clock cycles each bit (and each gap slot) is held on led. Must be >= 1.
- GAP_BITS, 4: number of dark bit periods before the first data bit. Must be >= 1.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data/in_carry are valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, WIDTH: adder sum.
- in_carry, input, 1: adder carry-out.
- led, output, 1: serial bit to the LED (registered).
- busy, output, 1: high while a frame is in progress.
- bit_idx, output, 7: index of the data bit currently on led.
- frame_done, output, 1: one-cycle pulse at the end of a frame.

Behaviour:
- Reset (reset=1 at a clk edge), effective on the next edge:
  - state=IDLE, led=0, in_ready=1, busy=0, frame_done=0, bit_idx=0.
  - Prescaler and shift register cleared.
  - Reset mid-frame aborts the frame: no frame_done pulse, captured word discarded.
- States: IDLE, GAP, SHIFT, DONE.
- IDLE:
  - in_ready=1, led=0.
  - When in_valid && in_ready at edge T, capture {in_carry, in_data} (carry dropped if CARRY_EN=0).
  - From T+1: state=GAP, in_ready=0, busy=1, prescaler=0.
- GAP:
  - led=0 for GAP_BITS*BIT_CYCLES cycles, then state=SHIFT.
  - bit_idx stays 0.
- SHIFT:
  - led = shift_reg[0], registered; visible from the first SHIFT cycle.
  - Prescaler counts 0..BIT_CYCLES-1. At terminal count, shift right by 1, bit_idx+1, prescaler=0.
  - After bit NBITS-1 completes its BIT_CYCLES, state=DONE.
  - BIT_CYCLES=1: one bit per cycle, no stalls.
- DONE (1 cycle):
  - led=0, frame_done=1, busy=0, in_ready=1, bit_idx=0.
  - Next edge: IDLE.
  - A word offered during DONE is accepted (back-to-back frames), and the next GAP starts one cycle later.
- Timing:
  - First data bit on led at T+1+GAP_BITS*BIT_CYCLES.
  - frame_done at T+1+(GAP_BITS+NBITS)*BIT_CYCLES.
- in_valid while busy=1: ignored. Input changes during a frame do not affect the captured word.
- in_valid held high continuously: a new frame is accepted each time in_ready=1.
- Counter widths:
  - Prescaler is clog2(BIT_CYCLES) bits (min 1) and never exceeds BIT_CYCLES-1.
  - Gap counter counts GAP_BITS slots.
  - bit_idx counts 0..NBITS-1 (NBITS <= 127); it never wraps within a frame.
- No combinational path from inputs to led.

Test Plan:
- Reset check: hold reset 3 cycles, then idle 10 cycles -> led=0, in_ready=1, busy=0, bit_idx=0, frame_done never pulses.
- Small frame (WIDTH=8, CARRY_EN=1, BIT_CYCLES=4, GAP_BITS=2), in_data=0xA5, in_carry=1, accepted at T:
  - led=0 for cycles T+1..T+8.
  - Then per 4-cycle slot, led = 1,0,1,0,0,1,0,1,1.
  - frame_done pulses exactly at T+45.
- Adder end-to-end (defaults): x1=0x5CD5153134D51531, x2=0xFFFFFFFFFFFFFFFF, carryin=1 gives sum 0x5CD5153134D51531, carry 1:
  - led reproduces the 65 bits LSB-first (1,0,0,0,1,1,0,0,...), then 1.
  - Each bit lasts 1250 cycles.
- Busy rejection: in the small config, pulse in_valid with 0xFF mid-SHIFT -> in_ready=0, the frame still shows 0xA5, and the 0xFF is never displayed.
- Reset mid-frame: assert reset during bit 3 of the small frame -> led=0 next cycle, no frame_done, next accepted word starts a full gap.
- Back-to-back: in_valid held high with 0x01 then 0x80 -> second frame's GAP starts the cycle after frame_done, and bit_idx restarts at 0.
